fmult_accum_seq: RTL and testbench

- Time-multiplexed G.726 predictor engine. It feeds the six zero-section pairs (Bn, DQn) and the two pole-section pairs (An, SRn) through one FMULT-equivalent multiplier, one pair per clock.
- It accumulates the eight WAn products into the signal estimates SEZ and SE, which makes it the consumer of FMULT-format products: it performs the ACCUM function serially.
- It sits between the coefficient/history registers and the adaptive quantizer input of the encoder and decoder.
- It replaces eight parallel multipliers with one multiplier plus an 8-cycle sequencer.

---
 rtl/fmult_accum_seq.sv | 113 +++++++++++
 tb/tb_fmult_accum_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fmult_accum_seq.sv
// Serial G.726 predictor: one FMULT-equivalent multiplier walks the six zero-section
// pairs and the two pole-section pairs, accumulating SEZI and SEI over eight cycles.
module fmult_accum_seq #(
    parameter int NPROD = 8,
    parameter int NZERO = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [16*NZERO-1:0]   b_flat,
    input  logic [11*NZERO-1:0]   dq_flat,
    input  logic [31:0]           a_flat,
    input  logic [21:0]           sr_flat,
    output logic                  busy,
    output logic                  done,
    output logic [14:0]           se,
    output logic [14:0]           sez
);
    localparam int IW = $clog2(NPROD);

    typedef enum logic {IDLE, CALC} state_t;

    state_t                   state;
    logic [IW-1:0]            idx;
    logic [15:0]              acc;
    logic [15:0]              sezi_r;
    logic [NPROD-1:0][15:0]   coef_r;
    logic [NPROD-1:0][10:0]   flt_r;

    // Operands are frozen at the accepting edge so the bus may move freely afterwards.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            coef_r <= {a_flat, b_flat};
            flt_r  <= {sr_flat, dq_flat};
        end
    end

    logic [15:0] c;
    logic [10:0] f;
    logic [14:0] c_neg;
    logic [12:0] cmag;
    logic [3:0]  cexp;
    logic [18:0] cmant_w;
    logic [5:0]  cmant;
    logic [12:0] prod;
    logic [7:0]  wmant;
    logic [4:0]  wexp;
    logic [16:0] wbase;
    logic [16:0] wshift;
    logic [14:0] wmag;
    logic [15:0] wa;
    logic [15:0] sum;

    always_comb begin
        c       = coef_r[idx];
        f       = flt_r[idx];
        c_neg   = 15'd16384 - {1'b0, c[15:2]};
        cmag    = c[15] ? c_neg[12:0] : c[14:2];
        cexp    = 4'd0;
        for (int i = 0; i < 13; i++)
            if (cmag[i]) cexp = 4'(i + 1);
        // Normalised mantissa keeps its leading one at bit 5.
        cmant_w = {cmag, 6'b0} >> cexp;
        cmant   = (cmag == 13'd0) ? 6'd32 : cmant_w[5:0];
        prod    = {7'b0, cmant} * {7'b0, f[5:0]} + 13'd48;
        wmant   = prod[11:4];
        wexp    = {1'b0, cexp} + {1'b0, f[9:6]};
        wbase   = {2'b0, wmant, 7'b0};
        wshift  = (wexp > 5'd26) ? (wbase << (wexp - 5'd26)) : (wbase >> (5'd26 - wexp));
        wmag    = wshift[14:0];
        wa      = (c[15] ^ f[10]) ? (16'd0 - {1'b0, wmag}) : {1'b0, wmag};
        sum     = acc + wa;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            idx    <= '0;
            acc    <= '0;
            sezi_r <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            se     <= '0;
            sez    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= sum;
                    idx <= idx + IW'(1);
                    if (idx == IW'(NZERO - 1))
                        sezi_r <= sum;
                    if (idx == IW'(NPROD - 1)) begin
                        se    <= sum[15:1];
                        sez   <= sezi_r[15:1];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fmult_accum_seq.sv
// Directed bench for fmult_accum_seq: an independent FMULT/ACCUM model feeds a
// scoreboard that is drained whenever the DUT pulses done.
module tb_fmult_accum_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [95:0] b_flat;
    logic [65:0] dq_flat;
    logic [31:0] a_flat;
    logic [21:0] sr_flat;
    logic        busy, done;
    logic [14:0] se, sez;

    fmult_accum_seq #(.NPROD(8), .NZERO(6)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .b_flat(b_flat), .dq_flat(dq_flat), .a_flat(a_flat), .sr_flat(sr_flat),
        .busy(busy), .done(done), .se(se), .sez(sez)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [29:0] sb[$];
    logic [15:0] coef[8];
    logic [10:0] flt[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] wa_model(input logic [15:0] cf, input logic [10:0] fl);
        int cm, ce, cmt, we, wm, wg;
        cm = cf[15] ? ((16384 - int'(cf >> 2)) & 8191) : int'(cf >> 2);
        ce = 0;
        while ((cm >> ce) != 0) ce++;
        cmt = (cm == 0) ? 32 : ((cm << 6) >> ce);
        we = ce + int'(fl[9:6]);
        wm = (cmt * int'(fl[5:0]) + 48) >> 4;
        wg = (we > 26) ? ((wm << 7) << (we - 26)) : ((wm << 7) >> (26 - we));
        wg = wg & 32767;
        return (cf[15] ^ fl[10]) ? 16'(-wg) : 16'(wg);
    endfunction

    function automatic logic [29:0] expect_out();
        logic [15:0] s, z;
        s = 16'd0;
        z = 16'd0;
        for (int i = 0; i < 8; i++) begin
            s = s + wa_model(coef[i], flt[i]);
            if (i == 5) z = s;
        end
        return {s[15:1], z[15:1]};
    endfunction

    task automatic apply_ops();
        for (int i = 0; i < 6; i++) begin
            b_flat[i*16 +: 16] = coef[i];
            dq_flat[i*11 +: 11] = flt[i];
        end
        a_flat  = {coef[7], coef[6]};
        sr_flat = {flt[7], flt[6]};
    endtask

    task automatic set_ops(input logic [15:0] cv, input logic [10:0] fv);
        for (int i = 0; i < 8; i++) begin
            coef[i] = cv;
            flt[i]  = fv;
        end
    endtask

    task automatic scramble_bus();
        b_flat  = {$urandom, $urandom, $urandom};
        dq_flat = {$urandom, $urandom, $urandom};
        a_flat  = $urandom;
        sr_flat = 22'($urandom);
    endtask

    // One evaluation; optionally re-pulse start before edge E<pulse_at> while busy.
    task automatic run_eval(input int pulse_at);
        int n, bcnt, dcnt;
        apply_ops();
        sb.push_back(expect_out());
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_bus();
        n = 0;
        bcnt = 0;
        while (!done && n < 20) begin
            if (busy) bcnt++;
            if (n + 1 == pulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        chk("latency", n, 8);
        chk("busy_cycles", bcnt, 8);
        @(posedge clk); #1;
        chk("done_width", done, 1'b0);
        dcnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("extra_done", dcnt, 0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 20);
    endtask

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) chk("sb_unexpected_done", 1, 0);
            else begin
                logic [29:0] e;
                e = sb.pop_front();
                chk("sb_se", se, e[29:15]);
                chk("sb_sez", sez, e[14:0]);
            end
        end
    end

    initial begin
        int n;
        reset_n = 1'b0;
        start   = 1'b0;
        set_ops(16'h0000, 11'h020);
        apply_ops();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_se", se, 15'h0);
        chk("rst_sez", sez, 15'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Homing sequence
        run_eval(0);
        chk("home_se", se, 15'h0000);
        chk("home_sez", sez, 15'h0000);

        // Pole only, positive then negative
        coef[6] = 16'h4000; flt[6] = 11'h2A0;
        chk("model_wa_pos", wa_model(coef[6], flt[6]), 16'h0430);
        run_eval(0);
        chk("pole_se", se, 15'h0218);
        chk("pole_sez", sez, 15'h0000);
        coef[6] = 16'hC000;
        chk("model_wa_neg", wa_model(coef[6], flt[6]), 16'hFBD0);
        run_eval(0);
        chk("neg_se", se, 15'h7DE8);
        chk("neg_sez", sez, 15'h0000);
        coef[6] = 16'h0000; coef[0] = 16'h4000; flt[0] = 11'h2A0;
        run_eval(0);
        chk("zero1_se", se, 15'h0218);
        chk("zero1_sez", sez, 15'h0218);

        // Full accumulation with an ignored start at E3
        set_ops(16'h4000, 11'h2A0);
        run_eval(3);
        chk("full_se", se, 15'h10C0);
        chk("full_sez", sez, 15'h0C90);

        // Back-to-back with start held high; bus changes mid-evaluation
        for (int i = 0; i < 8; i++) begin coef[i] = 16'($urandom); flt[i] = 11'($urandom); end
        apply_ops();
        sb.push_back(expect_out());
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin coef[i] = 16'($urandom); flt[i] = 11'($urandom); end
            apply_ops();
            if (k < 2) sb.push_back(expect_out());
            wait_done(n);
            chk("b2b_interval", n, 8);
            if (k == 2) start = 1'b0;
            else begin
                @(posedge clk); #1;
            end
        end
        repeat (12) @(posedge clk);
        #1;
        chk("b2b_sb_empty", sb.size(), 0);

        // Reset mid-evaluation aborts without done
        set_ops(16'h4000, 11'h2A0);
        apply_ops();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_se", se, 15'h0);
        chk("abort_sez", sez, 15'h0);
        chk("abort_done", done, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        chk("abort_no_done", n, 0);

        // Clean restart, large-exponent boundary, then random operands
        run_eval(0);
        chk("restart_se", se, 15'h10C0);
        set_ops(16'h0000, 11'h020);
        coef[7] = 16'h7FFC; flt[7] = 11'h3FF;
        coef[2] = 16'h8000; flt[2] = 11'h7FF;
        run_eval(0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) begin coef[i] = 16'($urandom); flt[i] = 11'($urandom); end
            run_eval(0);
        end
        chk("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
